alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Issues one operation at a time to the combinational ALU (ops/A/B in, 64-bit Z out).
//  Registers the opcode and operands, and waits a per-class latency (multicycle path for MUL/DIV).
//  Captures Z as lo/hi halves and returns it on a valid/ready response channel.
//  Rejects illegal opcodes and divide-by-zero without waiting on the ALU.
//  Sits between the control unit and the ALU, in place of direct ops/A/B wiring.
// PARAMETERS
//  SIMPLE_CYCLES  1  cycles the ALU is given for non-MUL/DIV ops (>=1)
//  MUL_CYCLES     4  cycles the ALU is given for MUL, 5'b01111 (>=1)
//  DIV_CYCLES     8  cycles the ALU is given for DIV, 5'b10000 (>=1)
// PORTS
//  clock      in   1   single clock, rising edge
//  clear_n    in   1   reset: synchronous, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   sequencer can accept a request
//  req_op     in   5   ALU opcode
//  req_a      in   32  operand A
//  req_b      in   32  operand B
//  alu_ops    out  5   registered opcode to the ALU
//  alu_a      out  32  registered operand A to the ALU
//  alu_b      out  32  registered operand B to the ALU
//  alu_z      in   64  ALU result
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer takes response
//  rsp_lo     out  32  result low word (quotient for DIV)
//  rsp_hi     out  32  result high word (remainder for DIV); 0 for non-MUL/DIV ops
//  rsp_err    out  1   1 = illegal opcode or DIV with B==0
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset (clear_n==0 at a rising edge):
//   - state<=IDLE; counter, alu_ops/a/b, rsp_lo/hi/err <= 0.
//   - req_ready and rsp_valid are gated to 0 while clear_n==0.
//   - Reset aborts any operation in flight; no response is produced for it.
//  States:
//   - IDLE: req_ready=1. On req_valid&&req_ready, latch op/A/B into alu_* regs, then branch:
//     - legal op, not DIV-by-zero: cnt<=L-1 (L = class latency) -> EXEC.
//     - illegal op (>5'b10010) or DIV with req_b==0: rsp_lo/hi<=0, rsp_err<=1 -> RESP.
//   - EXEC: req_ready=0.
//     - cnt!=0: cnt<=cnt-1.
//     - cnt==0: rsp_lo<=alu_z[31:0]; rsp_hi<=alu_z[63:32] for MUL/DIV, else 0; rsp_err<=0 -> RESP.
//   - RESP: rsp_valid=1. rsp_* held stable until rsp_valid&&rsp_ready, then -> IDLE.
//  Latency:
//   - legal op: rsp_valid rises exactly L cycles after the accept edge.
//   - error: rsp_valid rises 1 cycle after the accept edge.
//  Concurrency and hold:
//   - One op in flight; req_valid is ignored outside IDLE (no queue).
//   - A request can be accepted in the cycle right after the response handshake.
//   - alu_ops/a/b hold their last value after completion; they change only on accept or reset.
//  Opcodes 00000/00001/00010 (load, load-immediate, store) are legal and use the ADD result.
//  Counter width = clog2(max(SIMPLE,MUL,DIV)). The counter never wraps: it is only loaded on accept.
// TESTING
//  ADD 5+7, rsp_ready=1 -> rsp_valid 1 cycle after accept, lo=12, hi=0, err=0, then req_ready=1
//  MUL 0x00010000*0x00010000 -> rsp_valid exactly 4 cycles after accept, hi=1, lo=0, busy=1 throughout
//  DIV 7/2 -> after 8 cycles lo=3, hi=1; DIV 7/0 -> rsp_valid next cycle, err=1, lo=hi=0
//  Illegal op 5'b10101 -> err=1 next cycle; alu_ops shows 10101 but Z is ignored
//  rsp_ready=0 for 5 cycles after SUB 9-4 -> rsp_valid/lo=5 stable, req_ready=0, held req_valid ignored
//  clear_n low for 1 cycle mid-DIV (cnt=3) -> IDLE next cycle, rsp_valid never rises, outputs 0

Source files
------------

// File: rtl/alu_sequencer.sv
// Request/response front end for the combinational ALU.
// Holds operands steady for a per-class latency, then returns Z.
module alu_sequencer #(
  parameter int unsigned SIMPLE_CYCLES = 1,
  parameter int unsigned MUL_CYCLES    = 4,
  parameter int unsigned DIV_CYCLES    = 8
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [4:0]  alu_ops,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned MAX_SM =
    (SIMPLE_CYCLES > MUL_CYCLES) ? SIMPLE_CYCLES : MUL_CYCLES;
  localparam int unsigned MAXC =
    (MAX_SM > DIV_CYCLES) ? MAX_SM : DIV_CYCLES;
  localparam int unsigned CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SIMPLE_LD = CW'(SIMPLE_CYCLES - 1);
  localparam logic [CW-1:0] MUL_LD    = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD    = CW'(DIV_CYCLES - 1);

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_LAST = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ops_q, ops_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_q, hi_d;
  logic          err_q, err_d;

  logic [CW-1:0] ld_cnt;
  logic          req_bad;
  logic          wide_op;

  always_comb begin
    ld_cnt = SIMPLE_LD;
    unique case (1'b1)
      (req_op == OP_MUL): ld_cnt = MUL_LD;
      (req_op == OP_DIV): ld_cnt = DIV_LD;
      default: ;
    endcase
  end

  // Rejected up front so the ALU is never consulted for them.
  assign req_bad = (req_op > OP_LAST) ||
                   ((req_op == OP_DIV) && (req_b == 32'd0));
  assign wide_op = (ops_q == OP_MUL) || (ops_q == OP_DIV);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ops_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          ops_d = req_op;
          a_d   = req_a;
          b_d   = req_b;
          if (req_bad) begin
            lo_d    = '0;
            hi_d    = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = ld_cnt;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          lo_d    = alu_z[31:0];
          hi_d    = wide_op ? alu_z[63:32] : 32'd0;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = clear_n && (state_q == IDLE);
    rsp_valid = clear_n && (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  assign alu_ops = ops_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign rsp_lo  = lo_q;
  assign rsp_hi  = hi_q;
  assign rsp_err = err_q;

endmodule
